// File: rtl/fir_decim_sink.sv
// Decimating sink for the FIR output stream: drops the settling transient, keeps
// every DECIM-th sample after it, and buffers kept samples in a first-word-fall-through FIFO.
module fir_decim_sink #(
    parameter int DECIM = 2,
    parameter int SKIP  = 19,
    parameter int DEPTH = 16
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic                           In_valid,
    input  logic [0:15]                    In_data,
    output logic                           Out_valid,
    input  logic                           Out_ready,
    output logic [0:15]                    Out_data,
    output logic [0:$clog2(DEPTH+1)-1]     Count,
    output logic                           Overflow,
    output logic                           o_dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic {S_SKIP = 1'b0, S_RUN = 1'b1} state_t;
    localparam state_t S_INIT = (SKIP > 0) ? S_SKIP : S_RUN;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_skip_cnt;
    logic [SW-1:0]   w_skip_nxt;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_nxt;
    logic [0:15]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            w_keep;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_phase_nxt = r_phase;
        w_keep      = 1'b0;
        case (r_state)
            S_SKIP: begin
                if (In_valid) begin
                    w_skip_nxt = r_skip_cnt + 1'b1;
                    if (r_skip_cnt == SW'(SKIP - 1)) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (In_valid) begin
                    w_keep      = (r_phase == '0);
                    w_phase_nxt = (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + 1'b1;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Reader handshake: a sample transfers on a posedge where Out_valid and Out_ready are
    // both high; Out_data is stable while Out_valid is high and Out_ready is low.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = (r_count != '0) && Out_ready;
    assign w_push = w_keep && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state    <= S_INIT;
            r_skip_cnt <= '0;
            r_phase    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
            r_phase    <= w_phase_nxt;
            if (w_push) begin
                r_mem[r_wr_ptr] <= In_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_keep && !w_push) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign Out_valid   = (r_count != '0);
    assign Out_data    = r_mem[r_rd_ptr];
    assign Count       = r_count;
    assign Overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fir_decim_sink.sv
// Bench for fir_decim_sink: four instances with different DECIM/SKIP settings, a queue-based
// reference model checked every cycle, and hand-computed expectations for each scenario.
module tb_fir_decim_sink;

    logic        clk;
    logic        rstn      [4];
    logic        in_valid  [4];
    logic [0:15] in_data   [4];
    logic        out_ready [4];
    logic        out_valid [4];
    logic [0:15] out_data  [4];
    logic [0:4]  cnt       [4];
    logic        ovf       [4];
    logic        dbg       [4];

    int skip_p  [4] = '{19, 0, 0, 0};
    int decim_p [4] = '{2, 3, 2, 1};

    logic [15:0] exp_q [4][$];
    logic [15:0] got_q [4][$];
    int          m_skip  [4];
    int          m_phase [4];
    logic        m_ovf   [4];

    int   n_cmp;
    int   n_bad;
    logic chk_en;

    fir_decim_sink #(.DECIM(2), .SKIP(19), .DEPTH(16)) u0 (
        .CLK(clk), .RSTn(rstn[0]), .In_valid(in_valid[0]), .In_data(in_data[0]),
        .Out_valid(out_valid[0]), .Out_ready(out_ready[0]), .Out_data(out_data[0]),
        .Count(cnt[0]), .Overflow(ovf[0]), .o_dbg_state(dbg[0]));
    fir_decim_sink #(.DECIM(3), .SKIP(0), .DEPTH(16)) u1 (
        .CLK(clk), .RSTn(rstn[1]), .In_valid(in_valid[1]), .In_data(in_data[1]),
        .Out_valid(out_valid[1]), .Out_ready(out_ready[1]), .Out_data(out_data[1]),
        .Count(cnt[1]), .Overflow(ovf[1]), .o_dbg_state(dbg[1]));
    fir_decim_sink #(.DECIM(2), .SKIP(0), .DEPTH(16)) u2 (
        .CLK(clk), .RSTn(rstn[2]), .In_valid(in_valid[2]), .In_data(in_data[2]),
        .Out_valid(out_valid[2]), .Out_ready(out_ready[2]), .Out_data(out_data[2]),
        .Count(cnt[2]), .Overflow(ovf[2]), .o_dbg_state(dbg[2]));
    fir_decim_sink #(.DECIM(1), .SKIP(0), .DEPTH(16)) u3 (
        .CLK(clk), .RSTn(rstn[3]), .In_valid(in_valid[3]), .In_data(in_data[3]),
        .Out_valid(out_valid[3]), .Out_ready(out_ready[3]), .Out_data(out_data[3]),
        .Count(cnt[3]), .Overflow(ovf[3]), .o_dbg_state(dbg[3]));

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d]: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // reference model: skip the first SKIP valid samples, keep phase-0 samples, bounded queue
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            automatic logic keep = 1'b0;
            automatic logic pop;
            if (!rstn[k]) begin
                exp_q[k].delete();
                m_skip[k]  = 0;
                m_phase[k] = 0;
                m_ovf[k]   = 1'b0;
            end else begin
                if (in_valid[k]) begin
                    if (m_skip[k] < skip_p[k]) begin
                        m_skip[k]++;
                    end else begin
                        keep       = (m_phase[k] == 0);
                        m_phase[k] = (m_phase[k] + 1) % decim_p[k];
                    end
                end
                pop = (exp_q[k].size() != 0) && out_ready[k];
                if (pop) void'(exp_q[k].pop_front());
                if (keep) begin
                    if (exp_q[k].size() < 16) exp_q[k].push_back(in_data[k]);
                    else m_ovf[k] = 1'b1;
                end
            end
        end
    end

    // scoreboard compare and read-side capture
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                check("out_valid", k, 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
                check("count", k, 32'(cnt[k]), 32'(exp_q[k].size()));
                check("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
                if (exp_q[k].size() != 0) check("out_data", k, 32'(out_data[k]), 32'(exp_q[k][0]));
                if (out_valid[k] && out_ready[k]) got_q[k].push_back(out_data[k]);
            end
        end
    end

    initial begin
        automatic int          dec_exp [4] = '{1, 4, 7, 10};
        automatic logic        gap_v   [7] = '{1, 0, 0, 1, 1, 0, 1};
        automatic logic [15:0] gap_d   [7] = '{16'd5, 16'hDEAD, 16'hDEAD, 16'd6, 16'd7, 16'hDEAD, 16'd8};
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rstn[k]      = 1'b0;
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        tick(2);
        for (int k = 0; k < 4; k++) begin
            check("rst_valid", k, 32'(out_valid[k]), 0);
            check("rst_count", k, 32'(cnt[k]), 0);
            check("rst_overflow", k, 32'(ovf[k]), 0);
            check("rst_data", k, 32'(out_data[k]), 0);
            rstn[k] = 1'b1;
        end
        chk_en = 1'b1;

        // u0: 19 discarded samples, then 100 emerges one cycle later
        for (int i = 0; i < 19; i++) begin
            in_valid[0] = 1'b1; in_data[0] = 16'(i); tick(1);
        end
        check("skip_count", 0, 32'(cnt[0]), 0);
        check("skip_valid", 0, 32'(out_valid[0]), 0);
        in_data[0] = 16'd100; tick(1);
        in_valid[0] = 1'b0;
        check("first_valid", 0, 32'(out_valid[0]), 1);
        check("first_data", 0, 32'(out_data[0]), 100);

        // u0: phase is 1 after 100, so 102,104,106,108 are kept -> 5 buffered
        for (int i = 1; i <= 8; i++) begin
            in_valid[0] = 1'b1; in_data[0] = 16'(100 + i); tick(1);
        end
        in_valid[0] = 1'b0;
        check("mid_count", 0, 32'(cnt[0]), 5);
        rstn[0] = 1'b0; tick(1); rstn[0] = 1'b1;
        check("mid_rst_count", 0, 32'(cnt[0]), 0);
        check("mid_rst_valid", 0, 32'(out_valid[0]), 0);
        check("mid_rst_overflow", 0, 32'(ovf[0]), 0);
        check("mid_rst_data", 0, 32'(out_data[0]), 0);
        for (int i = 0; i < 19; i++) begin
            in_valid[0] = 1'b1; in_data[0] = 16'(300 + i); tick(1);
        end
        in_valid[0] = 1'b0; tick(1);
        check("reskip_count", 0, 32'(cnt[0]), 0);
        in_valid[0] = 1'b1; in_data[0] = 16'd200; tick(1);
        in_valid[0] = 1'b0;
        check("reskip_data", 0, 32'(out_data[0]), 200);
        check("reskip_valid", 0, 32'(out_valid[0]), 1);

        // u1: DECIM=3, continuous 1..12 with reader always ready
        out_ready[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_valid[1] = 1'b1; in_data[1] = 16'(i); tick(1);
        end
        in_valid[1] = 1'b0; tick(3);
        check("dec_len", 1, 32'(got_q[1].size()), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < got_q[1].size()) check("dec_val", 1, 32'(got_q[1][j]), 32'(dec_exp[j]));
        end

        // u2: gapped input, phase frozen while idle
        for (int i = 0; i < 7; i++) begin
            in_valid[2] = gap_v[i]; in_data[2] = gap_d[i]; tick(1);
        end
        in_valid[2] = 1'b0;
        check("gap_count", 2, 32'(cnt[2]), 2);
        out_ready[2] = 1'b1; tick(3);
        check("gap_len", 2, 32'(got_q[2].size()), 2);
        if (got_q[2].size() == 2) begin
            check("gap_first", 2, 32'(got_q[2][0]), 5);
            check("gap_second", 2, 32'(got_q[2][1]), 7);
        end

        // u3: overflow with reader stalled, then drain
        for (int i = 1; i <= 18; i++) begin
            in_valid[3] = 1'b1; in_data[3] = 16'(i); tick(1);
        end
        in_valid[3] = 1'b0;
        check("full_count", 3, 32'(cnt[3]), 16);
        check("full_overflow", 3, 32'(ovf[3]), 1);
        out_ready[3] = 1'b1; tick(18);
        out_ready[3] = 1'b0; tick(1);
        check("drain_len", 3, 32'(got_q[3].size()), 16);
        for (int j = 0; j < 16; j++) begin
            if (j < got_q[3].size()) check("drain_val", 3, 32'(got_q[3][j]), 32'(j + 1));
        end
        check("sticky_overflow", 3, 32'(ovf[3]), 1);

        // u3: push and pop together at full
        got_q[3].delete();
        rstn[3] = 1'b0; tick(1); rstn[3] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid[3] = 1'b1; in_data[3] = 16'(i); tick(1);
        end
        check("refill_count", 3, 32'(cnt[3]), 16);
        check("refill_overflow", 3, 32'(ovf[3]), 0);
        in_data[3] = 16'h7FFF; out_ready[3] = 1'b1; tick(1);
        in_valid[3] = 1'b0;
        check("pp_count", 3, 32'(cnt[3]), 16);
        check("pp_overflow", 3, 32'(ovf[3]), 0);
        tick(17);
        check("pp_len", 3, 32'(got_q[3].size()), 17);
        if (got_q[3].size() == 17) begin
            check("pp_head", 3, 32'(got_q[3][0]), 1);
            check("pp_last", 3, 32'(got_q[3][16]), 32'h7FFF);
        end
        out_ready[3] = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_decim_sink.md
Name: fir_decim_sink

Overview:
- Receiving end of the FIR filter output stream: consumes the filter's Data_valid/DataOut pair and discards the first SKIP valid samples (settling transient).
- Keeps every DECIM-th sample after that and buffers the kept samples in a first-word-fall-through FIFO.
- A downstream reader drains the FIFO over a valid/ready handshake.
- Sits directly after FIRFilter in the P2 datapath.

Parameters:
- DECIM, 2, decimation factor (>=1); 1 = keep every sample.
- SKIP, 19, number of initial valid input samples discarded before decimation starts (0 allowed).
- DEPTH, 16, FIFO depth in samples (power of 2, >=2).

Ports:
- CLK  in  1  clock, all logic on posedge.
- RSTn  in  1  synchronous active-low reset.
- In_valid  in  1  sample strobe, driven by filter Data_valid; one sample per CLK while high.
- In_data  in  [0:15]  filter DataOut; bit 0 = MSB, two's complement.
- Out_valid  out  1  FIFO non-empty.
- Out_ready  in  1  reader accepts head sample this cycle.
- Out_data  out  [0:15]  FIFO head sample, same bit order as In_data.
- Count  out  [0:clog2(DEPTH+1)-1]  current FIFO occupancy.
- Overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset, when RSTn = 0 at posedge:
  - FIFO emptied; read and write pointers = 0.
  - Out_valid = 0, Count = 0, Overflow = 0, Out_data = 0.
  - Skip counter = 0; phase counter = 0.
  - State = S_SKIP if SKIP > 0, else S_RUN.
  - Reset mid-stream discards all buffered data; no sample is written on the reset cycle.
- State machine:
  - S_SKIP:
    - Each cycle with In_valid = 1 increments the skip counter.
    - The sample is discarded.
    - When the counter reaches SKIP-1 on a valid cycle, go to S_RUN next cycle.
    - In_valid = 0 holds the state and counter.
  - S_RUN:
    - On each In_valid = 1, the sample is "kept" if phase == 0.
    - Phase then increments modulo DECIM (wraps DECIM-1 -> 0).
    - The first sample in S_RUN is always kept.
    - In_valid = 0 holds phase.
    - S_RUN is left only by reset.
- FIFO write: a kept sample is pushed at the posedge where it is presented. Push succeeds if Count < DEPTH, or if a pop occurs in the same cycle.
- Full, no pop: the kept sample is dropped and Overflow is set to 1. Overflow stays 1 until reset. Pointers and Count are unchanged.
- FIFO read:
  - Out_valid = (Count != 0); Out_data = mem[rd_ptr] (FWFT).
  - Pop occurs when Out_valid && Out_ready; rd_ptr advances and Count decrements.
  - Out_ready while empty has no effect.
- Latency: a kept sample written into an empty FIFO appears on Out_data, with Out_valid = 1, in the cycle after its In_valid posedge.
- Push and pop in the same cycle: Count unchanged, both pointers advance. Valid at any occupancy, including full and 1.
- Pointers wrap modulo DEPTH; Count ranges 0..DEPTH inclusive.
- Data path: In_data is stored unmodified. No rounding or sign handling; bit ordering is preserved.
- Out_data holds its value while Out_valid = 1 and Out_ready = 0.

Test Plan:
- Reset/skip: RSTn low 2 cycles, then 19 valid samples 0..18 -> no push, Count = 0, Out_valid = 0. Sample 19 (value 100) -> Out_valid = 1 and Out_data = 100 one cycle later.
- Decimation: SKIP = 0, DECIM = 3, In_valid continuous with data 1..12, Out_ready = 1 -> outputs exactly 1, 4, 7, 10 in order.
- Gapped input: DECIM = 2, In_valid pattern 1,0,0,1,1,0,1 with data 5,x,x,6,7,x,8 -> kept 5 and 7 only; phase frozen during gaps.
- Full/overflow: DEPTH = 16, DECIM = 1, SKIP = 0, Out_ready = 0, 18 samples 1..18 -> Count = 16, Overflow = 1. Drain returns 1..16; samples 17 and 18 are lost.
- Simultaneous push/pop at full: Count = 16, Out_ready = 1, In_valid = 1 with data 0x7FFF -> Count stays 16, Overflow unchanged (0). 0x7FFF is read out last.
- Reset mid-operation: Count = 5, RSTn low 1 cycle -> Count = 0, Out_valid = 0, Overflow = 0. The skip phase restarts: the next 19 valid samples are discarded.
